// File: rtl/control_sequencer.sv
// Microcoded control unit: instruction register, T-state counter, microcode decode and tick generation.
// Optional feature macro: CTRL_EARLY_STEP_RESET_EN (end each instruction after its last used T-state).
module control_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIV_BITS = 25,
    parameter int unsigned STEPS    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             manual,
    input  logic             step_btn,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             flag_c,
    input  logic             flag_z,
    output logic             tick,
    output logic [2:0]       step,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] operand,
    output logic [15:0]      ctrl,
    output logic             halted
);
    localparam int unsigned OPERAND_W = WIDTH - 4;
    localparam logic [2:0]  LAST_STEP = 3'(STEPS - 1);
    // Divider value one clk before it reaches all ones; tick is registered from it.
    localparam logic [DIV_BITS-1:0] DIV_PRE_WRAP = ~DIV_BITS'(1);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    logic [WIDTH-1:0]    ir, ir_next;
    logic [2:0]          step_next;
    logic                halted_next, tick_next;
    logic [DIV_BITS-1:0] div_cnt;
    logic [1:0]          sync_q;
    logic                btn_prev;
    logic                btn_rise, div_hit, instr_done;

    assign opcode   = ir[WIDTH-1 -: 4];
    assign operand  = {4'b0000, ir[OPERAND_W-1:0]};
    assign btn_rise = sync_q[1] & ~btn_prev;
    assign div_hit  = (div_cnt == DIV_PRE_WRAP);

    // Microcode decode: fetch in T0/T1, opcode-specific execute from T2
    always_comb begin
        ctrl = '0;
        case (step)
            3'd0: ctrl = C_CO | C_MI;
            3'd1: ctrl = C_RO | C_II | C_CE;
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
                    OP_LDI: ctrl = C_IO | C_AI;
                    OP_JMP: ctrl = C_IO | C_J;
                    OP_JC:  ctrl = flag_c ? (C_IO | C_J) : '0;
                    OP_JZ:  ctrl = flag_z ? (C_IO | C_J) : '0;
                    OP_OUT: ctrl = C_AO | C_OI;
                    OP_HLT: ctrl = C_HLT;
                    default: ctrl = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         ctrl = C_RO | C_AI;
                    OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
                    OP_STA:         ctrl = C_AO | C_RI;
                    default:        ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  ctrl = C_EO | C_AI | C_FI;
                    OP_SUB:  ctrl = C_EO | C_AI | C_FI | C_SU;
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

`ifdef CTRL_EARLY_STEP_RESET_EN
    logic [2:0] last_step;

    always_comb begin
        last_step = 3'd2;
        case (opcode)
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_ADD, OP_SUB: last_step = 3'd4;
            default:        last_step = 3'd2;
        endcase
    end

    assign instr_done = (step >= 3'd2) && (step == last_step);
`else
    assign instr_done = 1'b0;
`endif

    // Next-state: IR load, T-state advance and halt latch happen only on tick edges
    always_comb begin
        ir_next     = ir;
        step_next   = step;
        halted_next = halted;
        if (tick) begin
            if ((ctrl & C_II) != '0) ir_next = bus_in;
            if (step == LAST_STEP || instr_done) step_next = '0;
            else                                 step_next = step + 3'd1;
            if ((ctrl & C_HLT) != '0) halted_next = 1'b1;
        end
        tick_next = !halted_next && (manual ? btn_rise : div_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            step     <= '0;
            halted   <= 1'b0;
            tick     <= 1'b0;
            div_cnt  <= '0;
            sync_q   <= '0;
            btn_prev <= 1'b0;
        end else begin
            ir       <= ir_next;
            step     <= step_next;
            halted   <= halted_next;
            tick     <= tick_next;
            div_cnt  <= div_cnt + DIV_BITS'(1);
            sync_q   <= {sync_q[0], step_btn};
            btn_prev <= sync_q[1];
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level model checked every cycle plus directed literal checks.
module tb_control_sequencer;
    localparam int unsigned W          = 8;
    localparam int unsigned DB         = 3;
    localparam int unsigned ST         = 5;
    localparam int          DIV_PERIOD = 1 << DB;

    logic         clk = 1'b0, rst = 1'b1, manual = 1'b1, step_btn = 1'b0;
    logic         flag_c = 1'b0, flag_z = 1'b0;
    logic [W-1:0] bus_in = '0;
    logic         tick, halted;
    logic [2:0]   step;
    logic [3:0]   opcode;
    logic [W-1:0] operand;
    logic [15:0]  ctrl;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    control_sequencer #(.WIDTH(W), .DIV_BITS(DB), .STEPS(ST)) dut (
        .clk(clk), .rst(rst), .manual(manual), .step_btn(step_btn), .bus_in(bus_in),
        .flag_c(flag_c), .flag_z(flag_z), .tick(tick), .step(step), .opcode(opcode),
        .operand(operand), .ctrl(ctrl), .halted(halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Microprogram table per opcode, written straight from the instruction list
    function automatic logic [15:0] exp_ctrl(input logic [7:0] ir, input logic [2:0] s,
                                             input logic fc, input logic fz);
        logic [15:0] prog [0:7];
        for (int i = 0; i < 8; i++) prog[i] = 16'h0000;
        prog[0] = 16'h4004;
        prog[1] = 16'h1408;
        case (ir[7:4])
            4'd1:  begin prog[2] = 16'h4800; prog[3] = 16'h1200; end
            4'd2:  begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h0281; end
            4'd3:  begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h02C1; end
            4'd4:  begin prog[2] = 16'h4800; prog[3] = 16'h2100; end
            4'd5:  prog[2] = 16'h0A00;
            4'd6:  prog[2] = 16'h0802;
            4'd7:  prog[2] = fc ? 16'h0802 : 16'h0000;
            4'd8:  prog[2] = fz ? 16'h0802 : 16'h0000;
            4'd14: prog[2] = 16'h0110;
            4'd15: prog[2] = 16'h8000;
            default: ;
        endcase
        return prog[s];
    endfunction

    function automatic int ins_len(input logic [3:0] op);
`ifdef CTRL_EARLY_STEP_RESET_EN
        case (op)
            4'd1, 4'd4: return 4;
            4'd2, 4'd3: return 5;
            default:    return 3;
        endcase
`else
        return (op == 4'd0) ? ST : ST;
`endif
    endfunction

    // Model state: cycles since reset, press history, architectural registers
    logic [7:0] m_ir = '0;
    int         m_step = 0, cyc = 0, len;
    logic       m_halt = 1'b0, m_tick = 1'b0, chk_en = 1'b0;
    logic       btn_prev_s = 1'b0, p1 = 1'b0, p2 = 1'b0, pr;
    logic [15:0] w;

    always @(posedge clk) begin
        if (rst) begin
            m_ir = '0; m_step = 0; m_halt = 1'b0; m_tick = 1'b0; cyc = 0;
            btn_prev_s = 1'b0; p1 = 1'b0; p2 = 1'b0; chk_en = 1'b1;
        end else begin
            cyc++;
            if (m_tick) begin
                w   = exp_ctrl(m_ir, 3'(m_step), flag_c, flag_z);
                len = ins_len(m_ir[7:4]);
                if (len > ST) len = ST;
                m_step = (m_step + 1 >= len) ? 0 : m_step + 1;
                if (w[10]) m_ir = bus_in;
                if (w[15]) m_halt = 1'b1;
            end
            pr = step_btn && !btn_prev_s;
            btn_prev_s = step_btn;
            // Press first seen at edge k ticks after edge k+2; divider ticks at cyc = 7 mod 8
            m_tick = !m_halt && (manual ? p2 : ((cyc % DIV_PERIOD) == DIV_PERIOD - 1));
            p2 = p1;
            p1 = pr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tick",    32'(tick),    32'(m_tick));
            check("step",    32'(step),    32'(m_step));
            check("halted",  32'(halted),  32'(m_halt));
            check("opcode",  32'(opcode),  32'(m_ir[7:4]));
            check("operand", 32'(operand), 32'({4'b0000, m_ir[3:0]}));
            check("ctrl",    32'(ctrl),    32'(exp_ctrl(m_ir, 3'(m_step), flag_c, flag_z)));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int hold);
        int lat = -1;
        int extra = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (tick) begin lat = i; break; end
        end
        check("press_latency", lat, 3);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (tick) extra++;
        end
        if (hold > 0) check("hold_extra_ticks", extra, 0);
        #1; step_btn = 1'b0;
        cycles(3);
    endtask

    int seq_log[$];
`ifdef CTRL_EARLY_STEP_RESET_EN
    int exp_seq[$] = '{0, 1, 2, 0, 1, 2, 3, 4, 0};
`else
    int exp_seq[$] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
`endif

    initial begin
        int n, cnt;
        logic seen;
        rst = 1'b1; manual = 1'b1;
        cycles(3);
        rst = 1'b0;
        check("rst_ctrl", 32'(ctrl), 32'h4004);
        check("rst_step", 32'(step), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("model_rst_ctrl", 32'(exp_ctrl(m_ir, 3'(m_step), flag_c, flag_z)), 32'h4004);

        // LDI 0x5A
        seq_log.push_back(int'(step));
        press(8);
        seq_log.push_back(int'(step));
        check("t1_step", 32'(step), 1);
        check("t1_ctrl", 32'(ctrl), 32'h1408);
        bus_in = 8'h5A;
        press(0);
        seq_log.push_back(int'(step));
        check("ldi_opcode", 32'(opcode), 5);
        check("ldi_operand", 32'(operand), 32'h0A);
        check("ldi_t2_ctrl", 32'(ctrl), 32'h0A00);
        bus_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            press(0);
            seq_log.push_back(int'(step));
            if (step == 3'd0) break;
        end

        // ADD 0x2E
        bus_in = 8'h2E;
        for (int i = 0; i < 8; i++) begin
            press(0);
            seq_log.push_back(int'(step));
            if (step == 3'd2) check("add_t2_ctrl", 32'(ctrl), 32'h4800);
            if (step == 3'd3) check("add_t3_ctrl", 32'(ctrl), 32'h1020);
            if (step == 3'd4) check("add_t4_ctrl", 32'(ctrl), 32'h0281);
            if (step == 3'd0) break;
        end
        check("seq_len", seq_log.size(), exp_seq.size());
        for (int i = 0; i < seq_log.size() && i < exp_seq.size(); i++)
            check($sformatf("seq_%0d", i), seq_log[i], exp_seq[i]);

        // JC 0x7C then JZ 0x83
        bus_in = 8'h7C; flag_c = 1'b0;
        press(0); press(0);
        check("jc_nc_ctrl", 32'(ctrl), 32'h0000);
        flag_c = 1'b1; #1;
        check("jc_c_ctrl", 32'(ctrl), 32'h0802);
        for (int i = 0; i < 8 && step != 3'd0; i++) press(0);
        flag_c = 1'b0;
        bus_in = 8'h83; flag_z = 1'b1;
        press(0); press(0);
        check("jz_z_ctrl", 32'(ctrl), 32'h0802);
        flag_z = 1'b0; #1;
        check("jz_nz_ctrl", 32'(ctrl), 32'h0000);
        for (int i = 0; i < 8 && step != 3'd0; i++) press(0);

        // Reset during ADD T3 aborts the instruction
        bus_in = 8'h2E;
        press(0); press(0); press(0);
        check("abort_t3_ctrl", 32'(ctrl), 32'h1020);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("abort_ctrl", 32'(ctrl), 32'h4004);
        check("abort_opcode", 32'(opcode), 0);
        check("abort_step", 32'(step), 0);
        press(0);
        check("abort_resume_ctrl", 32'(ctrl), 32'h1408);

        // Reset coincident with the HLT T2 tick: no halt latch, no IR change
        bus_in = 8'hF0;
        press(0);
        check("hlt_t2_ctrl", 32'(ctrl), 32'h8000);
        step_btn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (tick) begin seen = 1'b1; break; end
        end
        check("coinc_tick_seen", 32'(seen), 1);
        #1; rst = 1'b1; step_btn = 1'b0;
        cycles(1);
        rst = 1'b0;
        check("coinc_halted", 32'(halted), 0);
        check("coinc_step", 32'(step), 0);
        check("coinc_opcode", 32'(opcode), 0);

        // HLT in auto mode
        rst = 1'b1; manual = 1'b0; bus_in = 8'hF0;
        cycles(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (halted) begin seen = 1'b1; break; end
        end
        check("auto_halted", 32'(seen), 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (tick) cnt++;
        end
        check("halted_ticks", cnt, 0);
        check("halted_still", 32'(halted), 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("unhalt", 32'(halted), 0);
        check("unhalt_ctrl", 32'(ctrl), 32'h4004);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            cycles(1);
            if (tick) begin n = i; break; end
        end
        check("auto_first_tick", n, DIV_PERIOD - 1);
        cycles(1);
        check("auto_resume_step", 32'(step), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit breadboard-style computer. It replaces DIP-switch driving of the bus control lines and the free-running divided clock. It holds the instruction register, a T-state counter and the microcode decoder, and it generates a single-cycle step enable (`tick`) for every datapath block on the 100 MHz `clk`. Bus width, divider length and step depth are parametrised, and the block adds conditional jumps, halt and a manual single-step mode.

## Interface
- `WIDTH`, 8: bus width; must be ≥ 5.
- `DIV_BITS`, 25: auto-mode tick period is 2^DIV_BITS clk.
- `STEPS`, 5: T-states per instruction; legal range 5..8.
- `clk` in 1: system clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `manual` in 1: 1 selects step-button mode; 0 selects divider mode.
- `step_btn` in 1: debounced step button, asynchronous to `clk`.
- `bus_in` in WIDTH: main bus value, sampled when II is high.
- `flag_c`, `flag_z` in 1 each: ALU flags-register outputs.
- `tick` out 1: one-clk step-enable pulse.
- `step` out 3: current T-state.
- `opcode` out 4: IR[WIDTH-1 -: 4].
- `operand` out WIDTH: IR[WIDTH-5:0], zero-extended; used by IO.
- `ctrl` out 16: control word. Bit order [15..0] = HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
- `halted` out 1: latched halt.

## Operation
- `ctrl` is combinational from IR, `step`, `flag_c` and `flag_z`. It is valid for the whole T-state. Datapath blocks act only on the clk edge where `tick`=1.
- Fixed steps:
  - T0: CO|MI.
  - T1: RO|II|CE.
- T2+ by opcode:
  - 0 NOP: nothing.
  - 1 LDA: IO|MI, then RO|AI.
  - 2 ADD: IO|MI, then RO|BI, then EO|AI|FI.
  - 3 SUB: same as ADD, with SU added in the last step.
  - 4 STA: IO|MI, then AO|RI.
  - 5 LDI: IO|AI.
  - 6 JMP: IO|J.
  - 7 JC: IO|J only if `flag_c`=1, otherwise nothing.
  - 8 JZ: IO|J only if `flag_z`=1, otherwise nothing.
  - 14 OUT: AO|OI.
  - 15 HLT: HLT.
  - 9–13: NOP.
  - Steps not listed are all zero.
- On a `tick` edge:
  - IR ← `bus_in` if II=1.
  - `step` advances by 1 and wraps to 0 after STEPS-1.
  - `halted` ← 1 if HLT=1.
- Tick source:
  - Auto mode: the divider counter increments every clk regardless of mode. `tick`=1 when the counter is all ones, `manual`=0 and `halted`=0.
  - Manual mode: `step_btn` passes through a 2-flop synchroniser, then rising-edge detection. Each press yields exactly one `tick` if `manual`=1 and `halted`=0. Holding the button yields no further ticks.
- Halted: no ticks are generated. Only `rst` clears `halted`.
- Mode switch at any time takes effect on the next clk. The divider is not cleared on a switch.

## Timing
- Reset values: IR=0, `step`=0, divider=0, synchroniser and edge flops=0, `tick`=0, `halted`=0. Therefore `ctrl`=CO|MI (0x4004), `opcode`=0 and `operand`=0 after reset.
- `rst` mid-instruction aborts the instruction; the next tick executes T0.
- `rst` takes priority over a coincident `tick`: no IR load and no halt latch.
- Manual latency: `step_btn` first sampled high at edge k gives `tick` high for the cycle after edge k+2.
- Auto mode: first `tick` at 2^DIV_BITS-1 clk after reset, then every 2^DIV_BITS clk.
- IR change from II is visible in `ctrl` from the cycle after the T1 tick edge, which is step T2.
- JC/JZ use the flag values present during T2.

## Configuration
- `CTRL_EARLY_STEP_RESET_EN`
  - Defined: on a tick in step s ≥ 2, `step` goes to 0 if s = len-1. Instruction lengths: NOP/unused 3, LDA/STA 4, ADD/SUB 5, LDI/JMP/JC/JZ/OUT/HLT 3. Lengths do not depend on flags. STEPS-1 still forces a wrap.
  - Undefined: every instruction runs all STEPS T-states.

## Test plan
- Reset, `manual`=1: `ctrl`=0x4004, `step`=0, `tick`=0. One press → exactly one `tick` 3 clk later; `step`=1 and `ctrl`=RO|II|CE. Holding the button gives no second tick.
- `bus_in`=0x5A during the T1 tick → `opcode`=5, `operand`=0x0A, T2 `ctrl`=IO|AI.
- JC (0x7C): with `flag_c`=0, T2 `ctrl`=0. With `flag_c`=1, T2 `ctrl`=IO|J.
- HLT (0xF0), `DIV_BITS`=3, auto mode: `halted`=1 after the T2 tick; no `tick` in the next 100 clk; `rst` clears it and resumes from T0.
- With the macro defined, run LDI then ADD: `step` sequences 0,1,2,0,1,2,3,4,0. Undefined: LDI runs 0..4.
- Assert `rst` during the ADD T3 step → next tick executes T0; `ctrl`=0x4004 and IR=0 immediately after the reset edge.
